// File: rtl/engine_rd_arbiter_pkg.sv
// engine_arb_pkg: shared widths and the engine-index width helper for engine_rd_arbiter
package engine_arb_pkg;
  localparam int LEN_W = 8;
  localparam int SIZE_W = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W = 2;
  localparam int OUT_W = 5;
  localparam int GCNT_W = 32;
  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  function automatic int eng_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/engine_rd_arbiter_if.sv
// engine_rd_arbiter_if: AXI4 AR + R channel bundle shared by the arbiter and the memory side
interface engine_rd_arbiter_if #(
  parameter int ID_WIDTH = 5,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 1024,
  parameter int ARUSER_WIDTH = 8
);
  import engine_arb_pkg::*;
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_W-1:0] arlen;
  logic [SIZE_W-1:0] arsize;
  logic [BURST_W-1:0] arburst;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [RESP_W-1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/engine_rd_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching from the index after ptr and wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int EB = 2
) (
  input  logic [N-1:0]  req,
  input  logic [EB-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [EB-1:0] idx,
  output logic          any
);
  logic [EB-1:0] c;
  // walk farthest-first so the nearest requester after ptr is the last writer
  always_comb begin
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = EB'((int'(ptr) + k) % N);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/engine_rd_arbiter.sv
// engine_rd_arbiter: round-robin share of one AXI4 read port among NUM_ENGINES read engines.
// Optional per-engine grant counters when ENGINE_RD_ARB_PERF_EN is defined.
module engine_rd_arbiter
  import engine_arb_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int SUB_ID_WIDTH = 3,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 1024,
  parameter int ARUSER_WIDTH = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_ENGINES-1:0]                 e_arvalid,
  output logic [NUM_ENGINES-1:0]                 e_arready,
  input  logic [NUM_ENGINES*ADDR_WIDTH-1:0]      e_araddr,
  input  logic [NUM_ENGINES*LEN_W-1:0]           e_arlen,
  input  logic [NUM_ENGINES*SIZE_W-1:0]          e_arsize,
  input  logic [NUM_ENGINES*ARUSER_WIDTH-1:0]    e_aruser,
  input  logic [NUM_ENGINES*SUB_ID_WIDTH-1:0]    e_arid,
  output logic [NUM_ENGINES-1:0]                 e_rvalid,
  input  logic [NUM_ENGINES-1:0]                 e_rready,
  output logic [DATA_WIDTH-1:0]                  e_rdata,
  output logic [RESP_W-1:0]                      e_rresp,
  output logic                                   e_rlast,
  output logic [SUB_ID_WIDTH-1:0]                e_rid,
  output logic                                   o_bad_rid,
  output logic [NUM_ENGINES*OUT_W-1:0]           o_outstanding,
  output logic [NUM_ENGINES*GCNT_W-1:0]          o_grant_cnt,
  input  logic                                   i_perf_clear,
  engine_rd_arbiter_if.master                    m_axi
);
  localparam int ENG_BITS = eng_bits(NUM_ENGINES);
  localparam int ID_WIDTH = ENG_BITS + SUB_ID_WIDTH;
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ENG_BITS:0] NE = (ENG_BITS+1)'(NUM_ENGINES);
  logic [ENG_BITS-1:0] ptr, idx, sel;
  logic [NUM_ENGINES-1:0] req, gnt, inc, dec;
  logic any, load, bad, r_hs;
  logic [OUT_W-1:0] cnt [NUM_ENGINES];
  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
    assign req[g] = e_arvalid[g] && cnt[g] < MAX_CNT;
    assign inc[g] = load && idx == ENG_BITS'(g);
    assign dec[g] = r_hs && m_axi.rlast && sel == ENG_BITS'(g);
    assign o_outstanding[g*OUT_W +: OUT_W] = cnt[g];
  end
  rr_arbiter #(.N(NUM_ENGINES), .EB(ENG_BITS)) u_rr (
    .req(req), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any)
  );
  assign load = (!m_axi.arvalid || m_axi.arready) && any;
  assign e_arready = (load && rst_n) ? gnt : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_axi.arvalid <= 1'b0;
      m_axi.arid <= '0;
      m_axi.araddr <= '0;
      m_axi.arlen <= '0;
      m_axi.arsize <= '0;
      m_axi.arburst <= '0;
      m_axi.aruser <= '0;
      ptr <= ENG_BITS'(NUM_ENGINES - 1);
    end else if (load) begin
      m_axi.arvalid <= 1'b1;
      m_axi.arid <= {idx, e_arid[idx*SUB_ID_WIDTH +: SUB_ID_WIDTH]};
      m_axi.araddr <= e_araddr[idx*ADDR_WIDTH +: ADDR_WIDTH];
      m_axi.arlen <= e_arlen[idx*LEN_W +: LEN_W];
      m_axi.arsize <= e_arsize[idx*SIZE_W +: SIZE_W];
      m_axi.arburst <= BURST_INCR;
      m_axi.aruser <= e_aruser[idx*ARUSER_WIDTH +: ARUSER_WIDTH];
      ptr <= idx;
    end else if (m_axi.arready) m_axi.arvalid <= 1'b0;
  // beats whose engine field names no engine are sunk and flagged
  assign sel = m_axi.rid[ID_WIDTH-1:SUB_ID_WIDTH];
  assign bad = {1'b0, sel} >= NE;
  assign e_rvalid = bad ? '0 : (NUM_ENGINES'(m_axi.rvalid) << sel);
  assign m_axi.rready = bad || e_rready[sel];
  assign r_hs = m_axi.rvalid && m_axi.rready && !bad;
  assign e_rdata = m_axi.rdata;
  assign e_rresp = m_axi.rresp;
  assign e_rlast = m_axi.rlast;
  assign e_rid = m_axi.rid[SUB_ID_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_ENGINES; i++) cnt[i] <= '0;
    else for (int i = 0; i < NUM_ENGINES; i++)
      if (inc[i] != dec[i]) cnt[i] <= inc[i] ? cnt[i] + 1'b1 : (cnt[i] != '0 ? cnt[i] - 1'b1 : cnt[i]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_bad_rid <= 1'b0;
    else if (m_axi.rvalid && bad) o_bad_rid <= 1'b1;
`ifdef ENGINE_RD_ARB_PERF_EN
  logic [GCNT_W-1:0] gcnt [NUM_ENGINES];
  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_perf
    assign o_grant_cnt[g*GCNT_W +: GCNT_W] = gcnt[g];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_ENGINES; i++) gcnt[i] <= '0;
    else for (int i = 0; i < NUM_ENGINES; i++)
      gcnt[i] <= i_perf_clear ? '0 : (inc[i] && gcnt[i] != '1 ? gcnt[i] + 1'b1 : gcnt[i]);
`else
  logic unused_perf_clear;
  assign unused_perf_clear = i_perf_clear;
  assign o_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_engine_rd_arbiter.sv
// tb_engine_rd_arbiter: directed, table-driven and randomized checks of engine_rd_arbiter
module tb_engine_rd_arbiter;
  localparam int N = 4, SW = 3, AW = 64, DW = 1024, UW = 8, IW = 5;
  localparam int N3 = 3, DW3 = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic perf_clear = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] e_arvalid, e_arready, e_rvalid, e_rready;
  logic [N*AW-1:0] e_araddr;
  logic [N*8-1:0] e_arlen;
  logic [N*3-1:0] e_arsize;
  logic [N*UW-1:0] e_aruser;
  logic [N*SW-1:0] e_arid;
  logic [DW-1:0] e_rdata;
  logic [1:0] e_rresp;
  logic e_rlast, bad;
  logic [SW-1:0] e_rid;
  logic [N*5-1:0] outs;
  logic [N*32-1:0] gcnt;
  engine_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARUSER_WIDTH(UW)) m();
  engine_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n), .e_arvalid(e_arvalid), .e_arready(e_arready),
    .e_araddr(e_araddr), .e_arlen(e_arlen), .e_arsize(e_arsize), .e_aruser(e_aruser),
    .e_arid(e_arid), .e_rvalid(e_rvalid), .e_rready(e_rready), .e_rdata(e_rdata),
    .e_rresp(e_rresp), .e_rlast(e_rlast), .e_rid(e_rid), .o_bad_rid(bad),
    .o_outstanding(outs), .o_grant_cnt(gcnt), .i_perf_clear(perf_clear), .m_axi(m)
  );
  logic [N3-1:0] e3_arvalid, e3_arready, e3_rvalid, e3_rready;
  logic [N3*AW-1:0] e3_araddr = '0;
  logic [N3*8-1:0] e3_arlen = '0;
  logic [N3*3-1:0] e3_arsize = '0;
  logic [N3*UW-1:0] e3_aruser = '0;
  logic [N3*SW-1:0] e3_arid = '0;
  logic [DW3-1:0] e3_rdata;
  logic [1:0] e3_rresp;
  logic e3_rlast, bad3;
  logic [SW-1:0] e3_rid;
  logic [N3*5-1:0] outs3;
  logic [N3*32-1:0] gcnt3;
  engine_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW3), .ARUSER_WIDTH(UW)) m3();
  engine_rd_arbiter #(.NUM_ENGINES(N3), .DATA_WIDTH(DW3)) dut3 (
    .clk(clk), .rst_n(rst_n), .e_arvalid(e3_arvalid), .e_arready(e3_arready),
    .e_araddr(e3_araddr), .e_arlen(e3_arlen), .e_arsize(e3_arsize), .e_aruser(e3_aruser),
    .e_arid(e3_arid), .e_rvalid(e3_rvalid), .e_rready(e3_rready), .e_rdata(e3_rdata),
    .e_rresp(e3_rresp), .e_rlast(e3_rlast), .e_rid(e3_rid), .o_bad_rid(bad3),
    .o_outstanding(outs3), .o_grant_cnt(gcnt3), .i_perf_clear(perf_clear), .m_axi(m3)
  );
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int outst(input int i);
    return int'(outs[i*5 +: 5]);
  endfunction
  task automatic set_fields(input int e, input logic [63:0] a, input logic [2:0] id);
    e_araddr[e*AW +: AW] = a;
    e_arlen[e*8 +: 8] = 8'(e + 3);
    e_arsize[e*3 +: 3] = 3'(e);
    e_aruser[e*UW +: UW] = 8'(e * 17);
    e_arid[e*SW +: SW] = id;
  endtask
  task automatic do_reset();
    e_arvalid = '0; e_rready = '0; e3_arvalid = '0; e3_rready = '0;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rlast = 1'b0; m.rid = '0; m.rdata = '0; m.rresp = '0;
    m3.arready = 1'b0; m3.rvalid = 1'b0; m3.rlast = 1'b0; m3.rid = '0; m3.rdata = '0; m3.rresp = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic [4:0] rid;
    logic       rvalid;
    logic [3:0] rready;
    logic [3:0] x_rvalid;
    logic       x_rready;
    logic [2:0] x_rid;
  } rvec_t;
  rvec_t tbl[6];
  int m_out[N];
  int m_last, m_eng, g, eng;
  bit m_vld;
  logic [63:0] m_addr;
  logic [4:0] m_id;
  logic [7:0] m_len, m_user;
  logic [2:0] m_size;
  initial begin
    tbl[0] = '{5'd29, 1'b1, 4'b0000, 4'b1000, 1'b0, 3'd5};
    tbl[1] = '{5'd29, 1'b1, 4'b1000, 4'b1000, 1'b1, 3'd5};
    tbl[2] = '{5'd2,  1'b1, 4'b1110, 4'b0001, 1'b0, 3'd2};
    tbl[3] = '{5'd15, 1'b0, 4'b0010, 4'b0000, 1'b1, 3'd7};
    tbl[4] = '{5'd16, 1'b1, 4'b0100, 4'b0100, 1'b1, 3'd0};
    tbl[5] = '{5'd11, 1'b1, 4'b1101, 4'b0010, 1'b0, 3'd3};
    for (int e = 0; e < N; e++) set_fields(e, 64'h1000 * (e + 1), 3'(e + 1));
    do_reset();
    #1;
    chk("rst_arvalid", m.arvalid, 0);
    chk("rst_arid", m.arid, 0);
    chk("rst_araddr", m.araddr, 0);
    chk("rst_arburst", m.arburst, 0);
    chk("rst_outstanding", outs, 0);
    chk("rst_bad", bad, 0);
    chk("rst_arready", e_arready, 0);
    chk("rst_grant_cnt", 64'(gcnt != '0), 0);
    tick();
    // all engines request with a free slave: strict rotation from engine 0
    m.arready = 1'b1;
    e_arvalid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", e_arready, 64'(1) << (k % 4));
      tick();
      chk("rr_arvalid", m.arvalid, 1);
      chk("rr_arid", m.arid, ((k % 4) << 3) | (((k % 4) + 1) & 7));
      chk("rr_araddr", m.araddr, 64'h1000 * ((k % 4) + 1));
      chk("rr_arburst", m.arburst, 1);
    end
    e_arvalid = '0;
    tick();
    chk("rr_out0", outst(0), 2);
    chk("rr_out3", outst(3), 1);
`ifdef ENGINE_RD_ARB_PERF_EN
    chk("perf_cnt0", gcnt[31:0], 2);
    chk("perf_cnt1", gcnt[63:32], 1);
`endif
    // slave stalls with engine 1 loaded: register must hold
    do_reset();
    for (int e = 0; e < N; e++) set_fields(e, 64'h2000 + e, 3'(e + 1));
    e_arvalid = 4'b0010;
    #1;
    chk("stall_first", e_arready, 4'b0010);
    tick();
    e_arvalid = 4'b1111;
    set_fields(1, 64'hDEAD, 3'd6);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_noready", e_arready, 0);
      tick();
      chk("stall_arvalid", m.arvalid, 1);
      chk("stall_arid", m.arid, 10);
      chk("stall_araddr", m.araddr, 64'h2001);
    end
    m.arready = 1'b1;
    #1;
    chk("stall_next", e_arready, 4'b0100);
    tick();
    chk("stall_next_id", m.arid, 19);
    // engine 2 fills its outstanding budget, then one rlast frees a slot
    do_reset();
    for (int e = 0; e < N; e++) set_fields(e, 64'h3000 + e, 3'(e + 1));
    m.arready = 1'b1;
    e_arvalid = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("cap_load", e_arready, 4'b0100);
      tick();
    end
    #1;
    chk("cap_block", e_arready, 0);
    tick();
    chk("cap_out16", outst(2), 16);
    m.rvalid = 1'b1; m.rid = 5'd16; m.rlast = 1'b1; e_rready = 4'b0100;
    #1;
    chk("cap_rready", m.rready, 1);
    chk("cap_rvalid", e_rvalid, 4'b0100);
    chk("cap_still_block", e_arready, 0);
    tick();
    m.rvalid = 1'b0; m.rlast = 1'b0;
    chk("cap_out15", outst(2), 15);
    #1;
    chk("cap_regrant", e_arready, 4'b0100);
    tick();
    chk("cap_out16b", outst(2), 16);
    chk("cap_arid", m.arid, 19);
    // asynchronous reset with bursts outstanding
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", m.arvalid, 0);
    chk("arst_arid", m.arid, 0);
    chk("arst_araddr", m.araddr, 0);
    chk("arst_outstanding", outs, 0);
    chk("arst_arready", e_arready, 0);
    chk("arst_bad", bad, 0);
    tick();
    rst_n = 1'b1;
    // R routing vectors, no rlast so counters stay put
    do_reset();
    for (int i = 0; i < 6; i++) begin
      m.rid = tbl[i].rid; m.rvalid = tbl[i].rvalid; e_rready = tbl[i].rready;
      m.rdata = '0; m.rdata[63:0] = 64'hC0DE_0000 + i;
      #1;
      chk("tbl_rvalid", e_rvalid, tbl[i].x_rvalid);
      chk("tbl_rready", m.rready, tbl[i].x_rready);
      chk("tbl_rid", e_rid, tbl[i].x_rid);
      chk("tbl_rdata", e_rdata[63:0], 64'hC0DE_0000 + i);
      tick();
    end
    m.rvalid = 1'b0;
    chk("tbl_outs", outs, 0);
    chk("tbl_bad", bad, 0);
    // three-engine build: same-cycle load and rlast, then an unroutable beat
    m3.arready = 1'b1;
    e3_arvalid = 3'b001;
    #1;
    chk("n3_gnt", e3_arready, 3'b001);
    tick();
    chk("n3_out1", outs3[4:0], 1);
    m3.rvalid = 1'b1; m3.rid = 5'd0; m3.rlast = 1'b1; e3_rready = 3'b001;
    #1;
    chk("n3_gnt2", e3_arready, 3'b001);
    chk("n3_rready", m3.rready, 1);
    tick();
    chk("n3_samecyc", outs3[4:0], 1);
    e3_arvalid = '0; m3.rid = 5'd25; e3_rready = '0;
    #1;
    chk("n3_bad_rready", m3.rready, 1);
    chk("n3_bad_rvalid", e3_rvalid, 0);
    tick();
    m3.rvalid = 1'b0; m3.rlast = 1'b0;
    chk("n3_bad_flag", bad3, 1);
    chk("n3_bad_outs", outs3, 1);
    tick();
    chk("n3_bad_sticky", bad3, 1);
    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < N; i++) m_out[i] = 0;
    m_last = N - 1; m_vld = 0; m_eng = 0;
    m_addr = '0; m_id = '0; m_len = '0; m_size = '0; m_user = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_arvalid", m.arvalid, m_vld);
      if (m_vld) begin
        chk("rnd_arid", m.arid, m_id);
        chk("rnd_araddr", m.araddr, m_addr);
        chk("rnd_arlen", m.arlen, m_len);
        chk("rnd_arsize", m.arsize, m_size);
        chk("rnd_aruser", m.aruser, m_user);
      end
      for (int i = 0; i < N; i++) chk("rnd_outstanding", outst(i), m_out[i]);
      e_arvalid = 4'($urandom);
      for (int e = 0; e < N; e++) begin
        e_araddr[e*AW +: AW] = {$urandom, $urandom};
        e_arlen[e*8 +: 8] = 8'($urandom);
        e_arsize[e*3 +: 3] = 3'($urandom);
        e_aruser[e*UW +: UW] = 8'($urandom);
        e_arid[e*SW +: SW] = 3'($urandom);
      end
      m.arready = ($urandom % 4) != 0;
      eng = int'($urandom % N);
      m.rvalid = 1'($urandom);
      m.rid = {2'(eng), 3'($urandom)};
      m.rlast = m_out[eng] > 0 && ($urandom % 4) != 0;
      e_rready = 4'($urandom);
      #1;
      g = -1;
      if (!m_vld || m.arready)
        for (int k = 1; k <= N; k++)
          if (g < 0 && e_arvalid[(m_last + k) % N] && m_out[(m_last + k) % N] < 16) g = (m_last + k) % N;
      chk("rnd_arready", e_arready, g >= 0 ? (64'(1) << g) : 0);
      chk("rnd_rvalid", e_rvalid, m.rvalid ? (64'(1) << eng) : 0);
      chk("rnd_rready", m.rready, e_rready[eng]);
      chk("rnd_rid", e_rid, m.rid[2:0]);
      if (g >= 0) begin
        m_vld = 1; m_eng = g; m_last = g; m_out[g]++;
        m_id = 5'(g * 8) | 5'(e_arid[g*SW +: SW]);
        m_addr = e_araddr[g*AW +: AW];
        m_len = e_arlen[g*8 +: 8];
        m_size = e_arsize[g*3 +: 3];
        m_user = e_aruser[g*UW +: UW];
      end else if (m.arready) m_vld = 0;
      if (m.rvalid && e_rready[eng] && m.rlast) m_out[eng]--;
      tick();
    end
    e_arvalid = '0; m.rvalid = 1'b0;
`ifdef ENGINE_RD_ARB_PERF_EN
    chk("perf_counted", 64'(gcnt != '0), 1);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    chk("perf_clear", 64'(gcnt != '0), 0);
`else
    chk("perf_tied", 64'(gcnt != '0), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/engine_rd_arbiter.md
ENGINE_RD_ARBITER -- requirements
Module: engine_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 4, number of read engines sharing one AXI master read port (legal 1..16).
REQ-002 SHALL have parameter SUB_ID_WIDTH, default 3, per-engine ID bits; ENG_BITS = max(1, clog2(NUM_ENGINES)); ID_WIDTH = ENG_BITS + SUB_ID_WIDTH.
REQ-003 SHALL have parameters ADDR_WIDTH (default 64), DATA_WIDTH (default 1024), ARUSER_WIDTH (default 8), MAX_OUTSTANDING (default 16, per engine).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 e_arvalid / e_arready  in / out  NUM_ENGINES  per-engine AR handshake.
REQ-007 e_araddr, e_arlen, e_arsize, e_aruser, e_arid  in  NUM_ENGINES x (ADDR_WIDTH, 8, 3, ARUSER_WIDTH, SUB_ID_WIDTH)  packed per-engine AR fields, engine 0 in LSBs.
REQ-008 m_axi_ar{id,addr,len,size,burst,user,valid} out, m_axi_arready in  standard AXI4 AR master; arburst fixed INCR.
REQ-009 m_axi_r{id,data,resp,last,valid} in, m_axi_rready out  AXI4 R master.
REQ-010 e_rvalid  out  NUM_ENGINES; e_rready  in  NUM_ENGINES; e_rdata, e_rresp, e_rlast, e_rid  out  broadcast (e_rid = low SUB_ID_WIDTH bits of m_axi_rid).
REQ-011 o_bad_rid  out  1  sticky illegal-RID flag; o_outstanding  out  NUM_ENGINES x 5  per-engine outstanding-burst counts.

Function
REQ-012 m_axi_arid SHALL be {engine index, e_arid}; remaining AR fields copied from the granted engine.
REQ-013 AR output SHALL be a single register stage: loaded when (!m_axi_arvalid || m_axi_arready) and an eligible request exists; otherwise held stable.
REQ-014 e_arready[g] SHALL be high only in the cycle engine g's request is loaded; at most one bit high per cycle.
REQ-015 Eligible = e_arvalid[i] && outstanding[i] < MAX_OUTSTANDING.
REQ-016 Arbitration SHALL be round-robin: search starts at index after last grant, wraps NUM_ENGINES-1 -> 0; pointer updates only on load.
REQ-017 Latency e_arvalid -> m_axi_arvalid SHALL be 1 cycle with empty output register; sustained throughput 1 AR/cycle while m_axi_arready high.
REQ-018 outstanding[i] SHALL +1 on load for i, -1 on R handshake with rlast routed to i; both same cycle -> unchanged; never wraps.
REQ-019 R routing: sel = m_axi_rid[ID_WIDTH-1:SUB_ID_WIDTH]; e_rvalid[sel] = m_axi_rvalid; m_axi_rready = e_rready[sel]; combinational, zero latency.
REQ-020 sel >= NUM_ENGINES SHALL set m_axi_rready = 1 (beat sunk), no e_rvalid, no counter change, o_bad_rid set until reset.
REQ-021 Engine deasserting e_arvalid while not granted SHALL be legal; request simply not eligible.

Reset
REQ-022 On rst_n low, asynchronously: m_axi_arvalid 0, all AR fields 0, RR pointer to NUM_ENGINES-1 (engine 0 first), outstanding 0, o_bad_rid 0, e_arready 0.
REQ-023 Reset mid-burst SHALL discard all state; no beat tracking survives.

Configuration
REQ-024 Macro ENGINE_RD_ARB_PERF_EN: when defined, output o_grant_cnt (NUM_ENGINES x 32) counts loads per engine, saturating at all-ones, cleared by input i_perf_clear (sync, 1 cycle); when undefined, o_grant_cnt tied 0, i_perf_clear ignored, no counter flops.

Structure
REQ-025 Package engine_arb_pkg SHALL hold ENG_BITS derivation function, AR field width constants, outstanding-counter width.
REQ-026 Sub-module rr_arbiter (request vector + pointer -> one-hot grant + index) SHALL be instantiated once.

Verification
REQ-027 NUM_ENGINES=4, all request at once, arready=1 -> grants 0,1,2,3,0 on consecutive cycles; arid high bits 0,1,2,3.
REQ-028 Engine 2 issues 16 ARs, no R returned -> 17th not granted, outstanding[2]=16; one rlast to engine 2 -> granted next cycle.
REQ-029 m_axi_arready low 5 cycles with engine 1 loaded -> AR fields stable, no further e_arready pulses.
REQ-030 R beat with rid={2'd3,3'd5}, e_rready[3]=0 -> m_axi_rready 0; e_rready[3]=1 -> e_rvalid[3]=1, e_rid=5.
REQ-031 NUM_ENGINES=3, rid high bits=3 -> beat sunk, o_bad_rid=1, counters unchanged; same-cycle AR load and rlast for engine 0 -> outstanding[0] unchanged.
REQ-032 rst_n asserted with 3 ARs outstanding -> all outputs at reset values within the same cycle; with PERF_EN, o_grant_cnt cleared by i_perf_clear.
